// File: rtl/mpd_pkg.sv
// Shared types and sizing helpers for the multi-slot packet dealer.
package mpd_pkg;

  typedef enum logic [2:0] {
    SLOT_FREE,
    SLOT_FILLING,
    SLOT_PENDING,
    SLOT_READY,
    SLOT_SENDING
  } slot_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_RECV,
    RX_DROP
  } rx_state_e;

  typedef enum logic {
    TX_IDLE,
    TX_SEND
  } tx_state_e;

  function automatic int tag_w(input int num_slots);
    return (num_slots > 1) ? $clog2(num_slots) : 1;
  endfunction

  function automatic int len_w(input int slot_depth);
    return $clog2(slot_depth + 1);
  endfunction

endpackage

// File: rtl/mpd_slot_ram.sv
// Frame buffer storage: one write port, one read port, registered read data.
module mpd_slot_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8192,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Read data holds when rd_en is low, so a stalled output beat stays put.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/multi_slot_packet_dealer.sv
// Buffers ingress frames into slots, asks a firewall for a verdict per frame,
// and transmits safe frames in verdict order while recycling slots.
module multi_slot_packet_dealer
  import mpd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SLOTS  = 4,
  parameter int SLOT_DEPTH = 2048,
  parameter int HDR_BEATS  = 4,
  localparam int TAG_W     = tag_w(NUM_SLOTS),
  localparam int LEN_W     = len_w(SLOT_DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rx_valid,
  input  logic                            rx_last,
  input  logic [DATA_WIDTH-1:0]           rx_data,
  output logic                            rx_ready,
  output logic                            fw_req_valid,
  input  logic                            fw_req_ready,
  output logic [HDR_BEATS*DATA_WIDTH-1:0] fw_req_header,
  output logic [TAG_W-1:0]                fw_req_tag,
  input  logic                            fw_rsp_valid,
  input  logic [TAG_W-1:0]                fw_rsp_tag,
  input  logic                            fw_rsp_safe,
  output logic                            tx_valid,
  output logic [DATA_WIDTH-1:0]           tx_data,
  output logic                            tx_last,
  input  logic                            tx_ready,
  output logic                            slot_available,
  output logic                            force_stop_rx,
  output logic                            invalidate_valid,
  output logic [TAG_W-1:0]                invalidate_tag
);

  localparam int HDR_W  = HDR_BEATS * DATA_WIDTH;
  localparam int ADDR_W = $clog2(NUM_SLOTS * SLOT_DEPTH);
  localparam int CNT_W  = TAG_W + 1;

  // Handshakes: a beat/request moves on a cycle where valid and ready are both
  // high; a raised valid keeps its payload stable until that cycle.

  slot_state_e            slot_state [NUM_SLOTS];
  logic [LEN_W-1:0]       slot_len   [NUM_SLOTS];
  logic [HDR_W-1:0]       slot_hdr   [NUM_SLOTS];

  rx_state_e              rx_state;
  logic [TAG_W-1:0]       rx_slot;
  logic [LEN_W-1:0]       rx_cnt;
  tx_state_e              tx_state;
  logic [TAG_W-1:0]       tx_slot;
  logic [LEN_W-1:0]       tx_idx;

  logic [TAG_W-1:0]       req_q [NUM_SLOTS];
  logic [TAG_W-1:0]       req_head, req_tail;
  logic [CNT_W-1:0]       req_cnt;
  logic [TAG_W-1:0]       txq   [NUM_SLOTS];
  logic [TAG_W-1:0]       txq_head, txq_tail;
  logic [CNT_W-1:0]       txq_cnt;

  logic                   tx_valid_q, tx_last_q, force_stop_q, inv_valid_q;
  logic [TAG_W-1:0]       inv_tag_q;

  logic                   any_free;
  logic [TAG_W-1:0]       first_free;
  logic                   rx_fire, rx_overflow, rx_write, rx_done;
  logic [TAG_W-1:0]       rx_cur_slot;
  logic [LEN_W-1:0]       rx_idx;
  logic                   req_pop, rsp_hit, rsp_safe_hit, rsp_kill;
  logic                   tx_pop, tx_fire, rd_en;
  logic [TAG_W-1:0]       rd_tag;
  logic [LEN_W-1:0]       rd_idx;
  logic [ADDR_W-1:0]      wr_addr, rd_addr;
  logic [DATA_WIDTH-1:0]  ram_q;

  always_comb begin
    any_free   = 1'b0;
    first_free = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (slot_state[i] == SLOT_FREE) begin
        any_free   = 1'b1;
        first_free = TAG_W'(i);
      end
    end
  end

  assign slot_available = any_free;
  assign rx_ready    = ~rst & ((rx_state == RX_RECV) | (rx_state == RX_DROP) |
                               ((rx_state == RX_IDLE) & any_free));
  assign rx_fire     = rx_valid & rx_ready;
  assign rx_cur_slot = (rx_state == RX_IDLE) ? first_free : rx_slot;
  assign rx_idx      = (rx_state == RX_IDLE) ? '0 : rx_cnt;
  assign rx_overflow = rx_fire & (rx_state == RX_RECV) & (rx_cnt == LEN_W'(SLOT_DEPTH));
  assign rx_write    = rx_fire & ((rx_state == RX_IDLE) | ((rx_state == RX_RECV) & ~rx_overflow));
  assign rx_done     = rx_write & rx_last;
  assign wr_addr     = ADDR_W'(rx_cur_slot) * ADDR_W'(SLOT_DEPTH) + ADDR_W'(rx_idx);

  assign fw_req_valid  = ~rst & (req_cnt != '0);
  assign fw_req_tag    = fw_req_valid ? req_q[req_head] : '0;
  assign fw_req_header = fw_req_valid ? slot_hdr[req_q[req_head]] : '0;
  assign req_pop       = fw_req_valid & fw_req_ready;

  assign rsp_hit      = fw_rsp_valid & (slot_state[fw_rsp_tag] == SLOT_PENDING);
  assign rsp_safe_hit = rsp_hit & fw_rsp_safe;
  assign rsp_kill     = rsp_hit & ~fw_rsp_safe;

  // Reads are issued one cycle ahead so the next beat is ready after a handshake.
  assign tx_pop  = (tx_state == TX_IDLE) & (txq_cnt != '0);
  assign tx_fire = tx_valid_q & tx_ready;
  assign rd_en   = tx_pop | (tx_fire & ~tx_last_q);
  assign rd_tag  = tx_pop ? txq[txq_head] : tx_slot;
  assign rd_idx  = tx_pop ? '0 : tx_idx + 1'b1;
  assign rd_addr = ADDR_W'(rd_tag) * ADDR_W'(SLOT_DEPTH) + ADDR_W'(rd_idx);

  assign tx_valid         = ~rst & tx_valid_q;
  assign tx_last          = ~rst & tx_last_q;
  assign tx_data          = tx_valid ? ram_q : '0;
  assign force_stop_rx    = ~rst & force_stop_q;
  assign invalidate_valid = ~rst & inv_valid_q;
  assign invalidate_tag   = invalidate_valid ? inv_tag_q : '0;

  mpd_slot_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (NUM_SLOTS * SLOT_DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (rx_write),
    .wr_addr (wr_addr),
    .wr_data (rx_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (ram_q)
  );

  // Every slot transition below starts from a distinct slot state, so two
  // events in one cycle never target the same slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_state[i] <= SLOT_FREE;
        slot_len[i]   <= '0;
      end
      rx_state     <= RX_IDLE;
      rx_slot      <= '0;
      rx_cnt       <= '0;
      tx_state     <= TX_IDLE;
      tx_slot      <= '0;
      tx_idx       <= '0;
      req_head     <= '0;
      req_tail     <= '0;
      req_cnt      <= '0;
      txq_head     <= '0;
      txq_tail     <= '0;
      txq_cnt      <= '0;
      tx_valid_q   <= 1'b0;
      tx_last_q    <= 1'b0;
      force_stop_q <= 1'b0;
      inv_valid_q  <= 1'b0;
      inv_tag_q    <= '0;
    end else begin
      force_stop_q <= 1'b0;
      inv_valid_q  <= 1'b0;

      case (rx_state)
        RX_IDLE: if (rx_fire) begin
          slot_hdr[first_free] <= HDR_W'(rx_data);
          rx_slot <= first_free;
          rx_cnt  <= LEN_W'(1);
          if (rx_last) begin
            slot_state[first_free] <= SLOT_PENDING;
            slot_len[first_free]   <= LEN_W'(1);
          end else begin
            slot_state[first_free] <= SLOT_FILLING;
            rx_state <= RX_RECV;
          end
        end
        RX_RECV: if (rx_fire) begin
          if (rx_overflow) begin
            force_stop_q        <= 1'b1;
            slot_state[rx_slot] <= SLOT_FREE;
            rx_state            <= rx_last ? RX_IDLE : RX_DROP;
          end else begin
            for (int b = 1; b < HDR_BEATS; b++) begin
              if (rx_cnt == LEN_W'(b)) slot_hdr[rx_slot][b*DATA_WIDTH +: DATA_WIDTH] <= rx_data;
            end
            rx_cnt <= rx_cnt + 1'b1;
            if (rx_last) begin
              slot_state[rx_slot] <= SLOT_PENDING;
              slot_len[rx_slot]   <= rx_cnt + 1'b1;
              rx_state            <= RX_IDLE;
            end
          end
        end
        RX_DROP: if (rx_fire && rx_last) rx_state <= RX_IDLE;
        default: rx_state <= RX_IDLE;
      endcase

      if (rx_done) begin
        req_q[req_tail] <= rx_cur_slot;
        req_tail        <= req_tail + 1'b1;
      end
      if (req_pop) req_head <= req_head + 1'b1;
      if (rx_done && !req_pop) req_cnt <= req_cnt + 1'b1;
      else if (!rx_done && req_pop) req_cnt <= req_cnt - 1'b1;

      if (rsp_safe_hit) begin
        slot_state[fw_rsp_tag] <= SLOT_READY;
        txq[txq_tail]          <= fw_rsp_tag;
        txq_tail               <= txq_tail + 1'b1;
      end
      if (rsp_kill) begin
        slot_state[fw_rsp_tag] <= SLOT_FREE;
        inv_valid_q            <= 1'b1;
        inv_tag_q              <= fw_rsp_tag;
      end

      case (tx_state)
        TX_IDLE: if (tx_pop) begin
          slot_state[txq[txq_head]] <= SLOT_SENDING;
          tx_slot    <= txq[txq_head];
          tx_idx     <= '0;
          tx_valid_q <= 1'b1;
          tx_last_q  <= (slot_len[txq[txq_head]] == LEN_W'(1));
          txq_head   <= txq_head + 1'b1;
          tx_state   <= TX_SEND;
        end
        TX_SEND: if (tx_fire) begin
          if (tx_last_q) begin
            tx_valid_q          <= 1'b0;
            tx_last_q           <= 1'b0;
            slot_state[tx_slot] <= SLOT_FREE;
            tx_state            <= TX_IDLE;
          end else begin
            tx_idx    <= tx_idx + 1'b1;
            tx_last_q <= (tx_idx + LEN_W'(2) == slot_len[tx_slot]);
          end
        end
        default: tx_state <= TX_IDLE;
      endcase

      if (rsp_safe_hit && !tx_pop) txq_cnt <= txq_cnt + 1'b1;
      else if (!rsp_safe_hit && tx_pop) txq_cnt <= txq_cnt - 1'b1;
    end
  end

endmodule

// File: doc/multi_slot_packet_dealer.md
MULTI_SLOT_PACKET_DEALER -- requirements
Module: multi_slot_packet_dealer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the byte-lane width.
REQ-002 SHALL have parameter NUM_SLOTS, default 4, meaning the number of frame buffers (power of 2, at least 2).
REQ-003 SHALL have parameter SLOT_DEPTH, default 2048, meaning the maximum beats per slot.
REQ-004 SHALL have parameter HDR_BEATS, default 4, meaning the header beats forwarded to the firewall.
REQ-005 SHALL have derived TAG_W = clog2(NUM_SLOTS) and LEN_W = clog2(SLOT_DEPTH+1).
REQ-006 SHALL have port clk, input, 1, the single clock; reset is synchronous and active-high.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have ports rx_valid/rx_last, input, 1 each, and rx_data, input, DATA_WIDTH, forming the ingress beat stream.
REQ-009 SHALL have port rx_ready, output, 1, meaning the ingress beat is accepted.
REQ-010 SHALL have ports fw_req_valid, output, 1; fw_req_ready, input, 1; fw_req_header, output, HDR_BEATS*DATA_WIDTH; fw_req_tag, output, TAG_W.
REQ-011 SHALL have ports fw_rsp_valid, input, 1; fw_rsp_tag, input, TAG_W; fw_rsp_safe, input, 1.
REQ-012 SHALL have ports tx_valid, output, 1; tx_data, output, DATA_WIDTH; tx_last, output, 1; tx_ready, input, 1.
REQ-013 SHALL have ports slot_available, force_stop_rx and invalidate_valid, output, 1 each, and invalidate_tag, output, TAG_W.

Function
REQ-014 SHALL track each slot in state FREE, FILLING, PENDING, READY or SENDING.
REQ-015 SHALL raise slot_available whenever any slot is FREE.
REQ-016 SHALL raise rx_ready when a frame is in progress (RX state RECV) or a slot is FREE (RX state IDLE), and SHALL hold it high in DROP.
REQ-017 SHALL, on the first accepted beat in IDLE, allocate the lowest-index FREE slot (FILLING) and enter RECV.
REQ-018 SHALL write accepted beats at sequential slot addresses and count length.
REQ-019 SHALL place beats 0..HDR_BEATS-1 in fw_req_header, beat 0 in the LSBs, with beats beyond the frame zero-padded.
REQ-020 SHALL, on an accepted rx_last, store the length, move the slot to PENDING, push its tag onto the NUM_SLOTS-deep request queue, and return to IDLE.
REQ-021 SHALL, on overflow (beat SLOT_DEPTH+1 arriving without a prior rx_last), pulse force_stop_rx for 1 cycle, FREE the slot, make no request, and enter DROP.
REQ-022 SHALL, in DROP, discard beats through rx_last and then return to IDLE.
REQ-023 SHALL present the queue head with fw_req_valid and pop it when fw_req_valid and fw_req_ready are both high; the outputs SHALL stay stable while stalled.
REQ-024 SHALL, on fw_rsp_valid with a PENDING tag and safe=1, move the slot to READY and push the tag onto the tx queue.
REQ-025 SHALL, on fw_rsp_valid with a PENDING tag and safe=0, FREE the slot and, in the next cycle, pulse invalidate_valid for 1 cycle with invalidate_tag = tag.
REQ-026 SHALL ignore fw_rsp_valid for a non-PENDING tag.
REQ-027 SHALL have a TX FSM with states IDLE and SEND; IDLE pops the tx queue head, sets the slot to SENDING and issues a memory read with 1-cycle latency; tx_valid SHALL be high on the next cycle.
REQ-028 SHALL advance tx_data on each tx handshake, assert tx_last on beat length-1, and FREE the slot in the cycle after the last handshake.
REQ-029 SHALL transmit in verdict order, not arrival order.
REQ-030 SHALL make a slot freed in cycle N allocatable in cycle N+1 and never in the same cycle.

Reset
REQ-031 SHALL, on rst, set all slots FREE, both FSMs IDLE and both queues empty.
REQ-032 SHALL drive all outputs to 0 in reset except slot_available, which SHALL be 1 in the first cycle after rst.
REQ-033 SHALL, on rst mid-frame or mid-transmission, abandon the frame without an invalidate pulse.

Structure
REQ-034 SHALL place the slot-state enum, RX/TX FSM enums and the TAG_W/LEN_W functions in the shared package mpd_pkg.
REQ-035 SHALL contain one sub-module, mpd_slot_ram: a 1R1W synchronous RAM of NUM_SLOTS*SLOT_DEPTH words with 1-cycle read latency.
REQ-036 SHALL implement the request and tx queues inline as tag FIFOs.

Verification
REQ-037 Single 64-beat frame, rsp safe=1 tag 0 -> fw_req_tag=0 with header = beats 0-3; tx emits 64 beats identical to the input; tx_last on beat 63; slot 0 FREE afterwards.
REQ-038 Two frames (tags 0, 1), responses tag1 safe then tag0 safe -> tx order frame1 then frame0.
REQ-039 Frame rsp safe=0 -> invalidate_valid 1 cycle with invalidate_tag=0; no tx_valid; slot_available=1.
REQ-040 2049-beat frame with SLOT_DEPTH=2048 -> force_stop_rx pulse on beat 2049; no fw request; subsequent frame uses slot 0.
REQ-041 Fill all 4 slots, hold fw_req_ready=0 -> slot_available=0 and rx_ready=0; release -> 4 requests, tags 0-3 in order.
REQ-042 rst asserted mid-tx with tx_ready toggling -> next cycle all slots FREE, tx_valid=0, no invalidate pulse.
